// File: rtl/twox1_rr_arbiter_pkg.sv
// rtl/twox1_rr_arbiter_pkg.sv - shared source encodings and state type for the 2:1 round-robin arbiter
package twox1_rr_arbiter_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/twox1mux.sv
// rtl/twox1mux.sv - parameterised two-input data multiplexer
module twox1mux #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_sel,
    output logic [DATA_WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/twox1_rr_arbiter.sv
// rtl/twox1_rr_arbiter.sv - two-requester round-robin arbiter feeding a one-beat output register
module twox1_rr_arbiter
    import twox1_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  y_valid,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  y_src,
    input  logic                  y_ready,
    output logic                  sel,
    output logic [CNT_WIDTH-1:0]  cnt_a,
    output logic [CNT_WIDTH-1:0]  cnt_b
);

    state_t                  r_state;
    logic                    r_last_src;
    logic [DATA_WIDTH-1:0]   r_y_data;
    logic                    r_y_src;
    logic [CNT_WIDTH-1:0]    r_cnt_a;
    logic [CNT_WIDTH-1:0]    r_cnt_b;

    logic                    w_load;
    logic                    w_sel;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_mux_data;

    // Slot may take a new beat when empty or when the held beat drains this cycle.
    assign w_load = (r_state == ST_EMPTY) | y_ready;

    always_comb begin
        w_sel = SRC_A;
        if (a_valid && b_valid) begin
            w_sel = ~r_last_src;
        end else if (b_valid) begin
            w_sel = SRC_B;
        end
    end

    assign a_ready = w_load & (w_sel == SRC_A) & ~rst;
    assign b_ready = w_load & (w_sel == SRC_B) & ~rst;
    assign w_xfer  = (a_ready & a_valid) | (b_ready & b_valid);

    twox1mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .i_a   (a_data),
        .i_b   (b_data),
        .i_sel (w_sel),
        .o_y   (w_mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_last_src <= SRC_B;
            r_y_data   <= '0;
            r_y_src    <= SRC_A;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
        end else if (w_xfer) begin
            r_state    <= ST_FULL;
            r_last_src <= w_sel;
            r_y_data   <= w_mux_data;
            r_y_src    <= w_sel;
            if (w_sel == SRC_A) begin
                if (r_cnt_a != '1) begin
                    r_cnt_a <= r_cnt_a + 1'b1;
                end
            end else begin
                if (r_cnt_b != '1) begin
                    r_cnt_b <= r_cnt_b + 1'b1;
                end
            end
        end else if (w_load) begin
            r_state <= ST_EMPTY;
        end
    end

    assign y_valid = (r_state == ST_FULL);
    assign y_data  = r_y_data;
    assign y_src   = r_y_src;
    assign sel     = w_sel;
    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;

endmodule

// File: tb/tb_twox1_rr_arbiter.sv
// tb/tb_twox1_rr_arbiter.sv - randomized scoreboard bench for the 2:1 round-robin arbiter
module tb_twox1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0;
    logic [3:0] a_data = 4'h0;
    logic       b_valid = 1'b0;
    logic [3:0] b_data = 4'h0;
    logic       y_ready = 1'b0;

    logic       a_ready, b_ready, y_valid, y_src, sel;
    logic [3:0] y_data;
    logic [7:0] cnt_a, cnt_b;

    logic       d2_a_ready, d2_b_ready, d2_y_valid, d2_y_src, d2_sel;
    logic [3:0] d2_y_data;
    logic [1:0] d2_cnt_a, d2_cnt_b;

    always #5 clk = ~clk;

    twox1_rr_arbiter #(.DATA_WIDTH(4), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_src(y_src), .y_ready(y_ready),
        .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    twox1_rr_arbiter #(.DATA_WIDTH(4), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(d2_a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(d2_b_ready),
        .y_valid(d2_y_valid), .y_data(d2_y_data), .y_src(d2_y_src), .y_ready(y_ready),
        .sel(d2_sel), .cnt_a(d2_cnt_a), .cnt_b(d2_cnt_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected beats as {src, data}, pushed on grant, popped when the consumer takes one.
    logic [4:0] sbq[$];

    bit m_known = 0;
    bit m_full  = 0;
    bit m_last  = 1;
    int m_cnt_a = 0;
    int m_cnt_b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cycle(input logic r, input logic av, input logic [3:0] ad,
                         input logic bv, input logic [3:0] bd, input logic yr);
        bit free, w, ea, eb;
        @(negedge clk);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
        y_ready = r ? 1'b0 : yr;
        #1;
        free = !m_full || y_ready;
        if (av && bv) w = !m_last;
        else          w = bv;
        ea = !r && free && !w;
        eb = !r && free && w;
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        if (m_known) begin
            chk("y_valid", y_valid, m_full);
            chk("cnt_a", cnt_a, sat(m_cnt_a, 255));
            chk("cnt_b", cnt_b, sat(m_cnt_b, 255));
            chk("cnt_a_w2", d2_cnt_a, sat(m_cnt_a, 3));
            chk("cnt_b_w2", d2_cnt_b, sat(m_cnt_b, 3));
            if (!r) chk("sel", sel, w);
        end
        if (r) begin
            m_known = 1; m_full = 0; m_last = 1; m_cnt_a = 0; m_cnt_b = 0;
            sbq.delete();
        end else if ((ea && av) || (eb && bv)) begin
            sbq.push_back({w, w ? bd : ad});
            m_full = 1; m_last = w;
            if (w) m_cnt_b++; else m_cnt_a++;
        end else if (free) begin
            m_full = 0;
        end
    endtask

    initial begin : monitor
        logic [4:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (y_valid === 1'b1 && y_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: beat %0h src %0d presented, none expected", y_data, y_src);
                end else begin
                    e = sbq.pop_front();
                    chk("y_data", y_data, e[3:0]);
                    chk("y_src", y_src, e[4]);
                end
            end
        end
    end

    initial begin : stim
        // Reset, then first contention goes to A
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 4'h3, 1, 4'h5, 0);
        cycle(0, 1, 4'h3, 1, 4'h5, 1);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("first_y_data", y_data, 4'h3);
        chk("first_y_src", y_src, 0);

        // Backpressure on a held 4'hA beat
        cycle(0, 1, 4'hA, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 4'($urandom), 1, 4'($urandom), 0);
            chk("bp_hold_data", y_data, 4'hA);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_ready", b_ready, 0);
        end
        cycle(0, 1, 4'h7, 1, 4'h9, 1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("bp_next_valid", y_valid, 1);
        chk("bp_next_data", y_data, 4'h9);
        chk("bp_next_src", y_src, 1);

        // Alternation from reset
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 4'($urandom), 1, 4'($urandom), 1);
            if (i > 0) chk("alt_src", y_src, (i - 1) % 2);
        end
        cycle(0, 0, 0, 0, 0, 1);
        chk("alt_src", y_src, 1);
        chk("alt_cnt_a", cnt_a, 3);
        chk("alt_cnt_b", cnt_b, 3);

        // Single requester B, back-to-back
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1, 4'($urandom), 1);
            if (i > 0) chk("b_only_valid", y_valid, 1);
        end
        cycle(0, 0, 0, 0, 0, 1);
        chk("b_only_valid", y_valid, 1);
        chk("b_only_cnt_b", cnt_b, 5);
        chk("b_only_cnt_a", cnt_a, 0);

        // Saturation on the narrow-counter instance
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 4'($urandom), 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("sat_cnt_a_w2", d2_cnt_a, 3);
        chk("sat_cnt_a_w8", cnt_a, 6);
        for (int i = 0; i < 2; i++) cycle(0, 1, 4'($urandom), 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("sat_hold_w2", d2_cnt_a, 3);

        // Reset while FULL and stalled discards the held beat
        cycle(0, 1, 4'hC, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("mid_full", y_valid, 1);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("mid_rst_valid", y_valid, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("mid_rst_never", y_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  1'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/twox1_rr_arbiter.md
TWOX1_RR_ARBITER -- requirements
Module: twox1_rr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of every data port.
REQ-002 Parameter CNT_WIDTH, default 8: width of each grant counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 a_valid  input  1  requester A offers a beat.
REQ-006 a_data  input  DATA_WIDTH  requester A payload.
REQ-007 a_ready  output  1  A beat accepted this cycle when a_valid is also high.
REQ-008 b_valid  input  1  requester B offers a beat.
REQ-009 b_data  input  DATA_WIDTH  requester B payload.
REQ-010 b_ready  output  1  B beat accepted this cycle when b_valid is also high.
REQ-011 y_valid  output  1  output register holds a beat.
REQ-012 y_data  output  DATA_WIDTH  registered payload.
REQ-013 y_src  output  1  source of the held beat: 0 = A, 1 = B.
REQ-014 y_ready  input  1  consumer accepts the beat this cycle.
REQ-015 sel  output  1  combinational grant driving the mux select: 0 = A, 1 = B.
REQ-016 cnt_a, cnt_b  output  CNT_WIDTH  saturating count of accepted A and B beats.

Function
REQ-017 load = ~y_valid | y_ready: the output slot is free or draining this cycle.
REQ-018 sel: both valid -> ~last_src; only a_valid -> 0; only b_valid -> 1; neither -> 0.
REQ-019 last_src is internal: it records the source of the most recent accepted beat.
REQ-020 a_ready = load & ~sel, and b_ready = load & sel.
REQ-021 Neither ready depends combinationally on y_valid of the other requester's data.
REQ-022 At most one requester transfers per cycle.
REQ-023 On a transfer, all of the following update next edge:
  - y_data <= selected data.
  - y_src <= sel.
  - y_valid <= 1.
  - last_src <= sel.
  - The matching counter increments.
REQ-024 When load is high and no transfer occurs, y_valid <= 0.
REQ-025 When y_valid & ~y_ready, y_valid, y_data and y_src hold unchanged, and both readies are 0.
REQ-026 Latency is one cycle from input transfer to y_valid.
REQ-027 Throughput is one beat per cycle with y_ready held high; there are no bubbles on a simultaneous drain and load.
REQ-028 With both requesters continuously valid and y_ready high, grants strictly alternate.
REQ-029 Counters saturate at all-ones and do not wrap.
REQ-030 State machine has two states:
  - EMPTY (y_valid = 0).
  - FULL (y_valid = 1).
REQ-031 EMPTY -> FULL on a transfer; EMPTY holds otherwise.
REQ-032 FULL -> FULL on y_ready with a transfer, or on ~y_ready.
REQ-033 FULL -> EMPTY on y_ready without a transfer.

Reset
REQ-034 On rst, the following take their reset values next edge:
  - y_valid = 0.
  - y_data = 0.
  - y_src = 0.
  - last_src = 1, so A wins the first contention.
  - cnt_a = cnt_b = 0.
  - State = EMPTY.
REQ-035 While rst is high, a_ready and b_ready are 0.
REQ-036 Reset during FULL discards the held beat; it is never presented after reset.

Structure
REQ-037 A shared package holds the source encoding constants SRC_A = 0 and SRC_B = 1, plus the two-state state enum.
REQ-038 The data selection instantiates the existing twox1mux sub-module:
  - DATA_WIDTH passes through.
  - a_data and b_data drive its inputs.
  - sel drives its select.
REQ-039 The mux output feeds the y_data register; no other sub-modules are used.

Verification
REQ-040 Reset check: rst high 2 cycles, then low -> y_valid = 0, cnt_a = cnt_b = 0; first contention with a_data = 4'h3, b_data = 4'h5 -> y_data = 4'h3, y_src = 0.
REQ-041 Alternation: both valid for 6 cycles, y_ready = 1 -> y_src sequence 0,1,0,1,0,1; cnt_a = cnt_b = 3.
REQ-042 Backpressure: y_ready = 0 while y_data = 4'hA is held for 4 cycles -> y_data stays 4'hA, a_ready = b_ready = 0; y_ready rises -> next beat appears the following cycle.
REQ-043 Single requester: only b_valid for 5 cycles with y_ready = 1 -> 5 B beats back-to-back; cnt_b = 5, cnt_a = 0.
REQ-044 Saturation: CNT_WIDTH = 2, 6 A beats -> cnt_a = 3 and holds at 3.
REQ-045 Reset mid-operation: rst asserted while FULL with y_ready = 0 -> y_valid = 0 next cycle; the held beat is never emitted.
